// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_COOL = 2'd2
  } arb_state_e;

  localparam int          STARVE_MAX_DEF = 4;
  localparam int          BURST_MAX_DEF  = 8;
  localparam logic [2:0]  DMA_FUNC3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM-stage core port and a loader/debug DMA
// port. The core normally wins; a starvation counter forces a DMA grant, and
// a locked burst is capped by BURST_MAX followed by one cool-down cycle so the
// core is never stalled for more than BURST_MAX consecutive cycles.
// BURST_MAX is assumed to be at least 2.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int BURST_MAX  = BURST_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic                  dma_lock,
  input  logic [DM_ADDRESS-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int BURST_W  = $clog2(BURST_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [BURST_W-1:0]  BURST_LIM  = BURST_W'(BURST_MAX);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                core_act;
  logic                gnt_raw;

  assign core_act   = core_rd | core_wr;
  assign core_rdata = mem_rdata;
  assign dma_rvalid = rvalid_q;
  assign dma_rdata  = rdata_q;

  // Grant decision from registered state, then steer the memory port; all
  // enables are held low while reset is asserted.
  always_comb begin
    gnt_raw = 1'b0;
    unique case (state_q)
      ST_IDLE: gnt_raw = dma_req & (~core_act | (starve_cnt_q == STARVE_LIM));
      ST_LOCK: gnt_raw = dma_req;
      default: gnt_raw = 1'b0;
    endcase
    dma_gnt    = reset & gnt_raw;
    core_stall = core_act & dma_gnt;
    if (dma_gnt) begin
      mem_rd    = ~dma_we;
      mem_wr    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_func3 = DMA_FUNC3_WORD;
    end else begin
      // A store wins if the core ever raises both, so rd and wr stay exclusive.
      mem_rd    = reset & core_rd & ~core_wr;
      mem_wr    = reset & core_wr;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      mem_func3 = core_func3;
    end
  end

  // Next-state logic for the burst FSM, the two counters and the read return.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    starve_cnt_d = starve_cnt_q;
    rvalid_d     = dma_gnt & ~dma_we;
    rdata_d      = (dma_gnt & ~dma_we) ? mem_rdata : rdata_q;

    if (!dma_req || dma_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (dma_gnt && dma_lock) begin
          state_d     = ST_LOCK;
          burst_cnt_d = BURST_W'(1);
        end
      end
      ST_LOCK: begin
        // Hitting the burst cap outranks a lock/request drop.
        if (dma_gnt && (burst_cnt_q + BURST_W'(1) == BURST_LIM)) begin
          state_d     = ST_COOL;
          burst_cnt_d = '0;
        end else if (!dma_req || !dma_lock) begin
          state_d     = ST_IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_rd = 1'b0, core_wr = 1'b0;
  logic [8:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [2:0]  core_func3 = '0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
  logic [8:0]  dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_rd, mem_wr;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  logic [31:0] mem_model [0:127];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_model[mem_addr[8:2]];
  always @(posedge clk) if (mem_wr) mem_model[mem_addr[8:2]] <= mem_wdata;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3), .core_rdata(core_rdata),
    .core_stall(core_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  task automatic clear_inputs();
    core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0; core_func3 = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_lock = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; core_rd = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
    @(negedge clk);
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b expected 0", dma_gnt); end
    checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b expected 0", core_stall); end
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_en got rd=%b wr=%b expected 0/0", mem_rd, mem_wr); end
    checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_rvalid got %b/%h expected 0/0", dma_rvalid, dma_rdata); end
    next_cycle();
    clear_inputs();
    #2 reset = 1'b1;
    next_cycle();
    $display("test_reset done");
  endtask

  task automatic test_core_write();
    core_wr = 1'b1; core_addr = 9'h010; core_wdata = 32'hDEADBEEF; core_func3 = 3'b010;
    @(negedge clk);
    checks++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin errors++; $display("FAIL core_wr_en got wr=%b rd=%b expected 1/0", mem_wr, mem_rd); end
    checks++; if (mem_addr !== 9'h010 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL core_wr_bus got %h/%h expected 010/deadbeef", mem_addr, mem_wdata); end
    checks++; if (core_stall !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL core_wr_arb got stall=%b gnt=%b expected 0/0", core_stall, dma_gnt); end
    next_cycle();
    clear_inputs();
    $display("test_core_write done");
  endtask

  task automatic test_starve();
    // Seed the word the DMA will read.
    core_wr = 1'b1; core_addr = 9'h020; core_wdata = 32'h12345678; core_func3 = 3'b010;
    next_cycle();
    clear_inputs();
    core_rd = 1'b1; core_addr = 9'h040; core_func3 = 3'b000;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h020;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (dma_gnt !== (k == 4)) begin errors++; $display("FAIL starve_gnt[%0d] got %b expected %b", k, dma_gnt, (k == 4)); end
      checks++; if (core_stall !== (k == 4)) begin errors++; $display("FAIL starve_stall[%0d] got %b expected %b", k, core_stall, (k == 4)); end
      if (k == 4) begin
        checks++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 9'h020 || mem_func3 !== 3'b010) begin
          errors++; $display("FAIL starve_dma_bus got rd=%b wr=%b addr=%h f3=%b expected 1/0/020/010", mem_rd, mem_wr, mem_addr, mem_func3);
        end
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk);
    checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h12345678) begin errors++; $display("FAIL starve_rdata got %b/%h expected 1/12345678", dma_rvalid, dma_rdata); end
    next_cycle();
    @(negedge clk);
    checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL starve_rvalid_pulse got %b expected 0", dma_rvalid); end
    next_cycle();
    $display("test_starve done");
  endtask

  task automatic test_burst();
    int run = 0;
    int max_run = 0;
    logic exp;
    core_rd = 1'b1; core_addr = 9'h044;
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 9'h020;
    // 4 starved cycles, 8 locked grants, 1 cool cycle, 3 starved cycles, grants again.
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      exp = (k >= 4 && k <= 11) || (k >= 16);
      checks++; if (dma_gnt !== exp) begin errors++; $display("FAIL burst_gnt[%0d] got %b expected %b", k, dma_gnt, exp); end
      if (k == 12) begin
        checks++; if (core_stall !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h044) begin
          errors++; $display("FAIL burst_cool got stall=%b rd=%b addr=%h expected 0/1/044", core_stall, mem_rd, mem_addr);
        end
      end
      run = core_stall ? run + 1 : 0;
      if (run > max_run) max_run = run;
      next_cycle();
    end
    checks++; if (max_run !== 8) begin errors++; $display("FAIL burst_max_stall got %0d expected 8", max_run); end
    clear_inputs();
    next_cycle();
    $display("test_burst done");
  endtask

  task automatic test_lock_drop();
    logic exp;
    core_rd = 1'b1; core_addr = 9'h048;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h020;
    for (int k = 0; k < 8; k++) begin
      dma_lock = (k < 6);
      @(negedge clk);
      exp = (k >= 4 && k <= 6);
      checks++; if (dma_gnt !== exp) begin errors++; $display("FAIL lockdrop_gnt[%0d] got %b expected %b", k, dma_gnt, exp); end
      if (k == 7) begin
        checks++; if (core_stall !== 1'b0 || mem_addr !== 9'h048) begin
          errors++; $display("FAIL lockdrop_core got stall=%b addr=%h expected 0/048", core_stall, mem_addr);
        end
      end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
    $display("test_lock_drop done");
  endtask

  task automatic test_reset_mid_burst();
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 9'h060; dma_wdata = 32'hA5A5A5A5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rstburst_gnt[%0d] got %b expected 1", k, dma_gnt); end
      if (k < 4) next_cycle();
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (dma_gnt !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b0 || core_stall !== 1'b0) begin
      errors++; $display("FAIL rstburst_abort got gnt=%b wr=%b rd=%b stall=%b expected 0/0/0/0", dma_gnt, mem_wr, mem_rd, core_stall);
    end
    next_cycle();
    core_rd = 1'b1; core_addr = 9'h04C; dma_we = 1'b0;
    #2 reset = 1'b1;
    @(negedge clk);
    checks++; if (dma_gnt !== 1'b0 || core_stall !== 1'b0) begin errors++; $display("FAIL rstburst_idle got gnt=%b stall=%b expected 0/0", dma_gnt, core_stall); end
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 9'h04C) begin errors++; $display("FAIL rstburst_core got rd=%b addr=%h expected 1/04c", mem_rd, mem_addr); end
    next_cycle();
    clear_inputs();
    next_cycle();
    $display("test_reset_mid_burst done");
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_starve();
    test_burst();
    test_lock_drop();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameters: DATA_W, 32, data width; DM_ADDRESS, 9, data-memory byte address width.
REQ-002 SHALL have parameters: STARVE_MAX, 4, denied-cycle limit before forced DMA grant; BURST_MAX, 8, maximum consecutive locked DMA grants.
REQ-003 SHALL use one clock; reset is asynchronous and active-low. Ports are named clk and reset as elsewhere in the codebase.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 core_rd  in  1  MEM-stage load request.
REQ-007 core_wr  in  1  MEM-stage store request.
REQ-008 core_addr  in  DM_ADDRESS  MEM-stage address.
REQ-009 core_wdata  in  DATA_W  MEM-stage store data.
REQ-010 core_func3  in  3  MEM-stage access size/sign code.
REQ-011 core_rdata  out  DATA_W  load data to the MEM/WB register.
REQ-012 core_stall  out  1  MEM stage must hold; its access was not performed this cycle.
REQ-013 dma_req  in  1  loader/debug access request, held until granted.
REQ-014 dma_we  in  1  1 = write, 0 = read.
REQ-015 dma_lock  in  1  requests back-to-back burst ownership.
REQ-016 dma_addr  in  DM_ADDRESS  DMA address.
REQ-017 dma_wdata  in  DATA_W  DMA write data.
REQ-018 dma_gnt  out  1  DMA access performed this cycle.
REQ-019 dma_rvalid  out  1  dma_rdata valid (registered).
REQ-020 dma_rdata  out  DATA_W  DMA read data.
REQ-021 mem_rd, mem_wr  out  1 each  data-memory read/write enables.
REQ-022 mem_addr / mem_wdata / mem_func3  out  DM_ADDRESS / DATA_W / 3  data-memory address, write data and size code.
REQ-023 mem_rdata  in  DATA_W  data-memory combinational read data.

Function
REQ-024 core_act SHALL be core_rd|core_wr. Arbitration SHALL be combinational each cycle from registered state.
REQ-025 FSM SHALL have states IDLE, LOCK and COOL.
REQ-026 In IDLE: dma_gnt = dma_req & (!core_act | starve_cnt==STARVE_MAX).
REQ-027 In LOCK: dma_gnt = dma_req.
REQ-028 In COOL: dma_gnt = 0 unconditionally.
REQ-029 core_stall SHALL equal core_act & dma_gnt. Otherwise the core access SHALL drive the mem_* outputs in the same cycle.
REQ-030 DMA accesses SHALL drive mem_func3 = 3'b010 (word); mem_rd = !dma_we, mem_wr = dma_we.
REQ-031 No owner SHALL drive mem_rd = mem_wr = 0. mem_rd and mem_wr SHALL never be high together.
REQ-032 core_rdata SHALL equal mem_rdata combinationally.
REQ-033 On a granted DMA read, dma_rdata SHALL register mem_rdata and dma_rvalid SHALL be 1 in the next cycle only.
REQ-034 starve_cnt SHALL increment on dma_req & !dma_gnt, saturate at STARVE_MAX, and clear on dma_gnt or !dma_req.
REQ-035 IDLE -> LOCK SHALL occur on dma_gnt & dma_lock; burst_cnt SHALL be set to 1.
REQ-036 In LOCK, each grant SHALL increment burst_cnt.
REQ-037 LOCK -> IDLE SHALL occur when !dma_req | !dma_lock.
REQ-038 LOCK -> COOL SHALL occur when a grant makes burst_cnt == BURST_MAX; this takes priority over REQ-037.
REQ-039 COOL -> IDLE SHALL occur after exactly one cycle; burst_cnt SHALL clear on leaving LOCK.
REQ-040 The bounded stall guarantee: core_stall SHALL never exceed BURST_MAX consecutive cycles.

Reset
REQ-041 While reset = 0: state = IDLE; starve_cnt, burst_cnt, dma_rvalid and dma_rdata = 0; mem_rd, mem_wr, dma_gnt and core_stall forced to 0.
REQ-042 Reset asserted mid-burst SHALL abort the burst immediately. The first cycle after release SHALL arbitrate as IDLE.

Structure
REQ-043 Package dmem_arb_pkg SHALL hold the state enum, the STARVE_MAX and BURST_MAX defaults, and DMA_FUNC3_WORD = 3'b010.
REQ-044 No sub-module SHALL be used; the counters and FSM are local.

Verification
REQ-045 Scenario 1: core_wr to address 0x010, data 0xDEADBEEF, with dma_req=0 -> mem_wr=1, mem_addr=0x010, core_stall=0, dma_gnt=0.
REQ-046 Scenario 2: continuous core_rd with dma_req=1 read 0x020 -> dma_gnt=0 for 4 cycles; on the 5th cycle dma_gnt=1 and core_stall=1; the next cycle dma_rvalid=1 with the memory word.
REQ-047 Scenario 3: dma_lock=1 and dma_req=1 for 12 cycles with core_act=1 -> 8 grants, then 1 COOL cycle (core served, core_stall=0), then grants resume.
REQ-048 Scenario 4: dma_lock dropped after 3 grants -> LOCK -> IDLE; the next cycle gives the core priority.
REQ-049 Scenario 5: reset pulsed low during grant 5 of a burst -> outputs 0 immediately; after release with dma_req=1 and core_act=1, dma_gnt=0.
